// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and its register slave.
// Master modports drive aw/w/ar payload and valids; slave modports drive readies and responses.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int USER_W = 1
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid, input awready,
    output wdata, wstrb, wuser, wvalid, input wready,
    input bresp, buser, bvalid, output bready
  );
  modport rd_mst (
    output araddr, arprot, aruser, arvalid, input arready,
    input rdata, rresp, ruser, rvalid, output rready
  );
  modport wr_slv (
    input awaddr, awprot, awuser, awvalid, output awready,
    input wdata, wstrb, wuser, wvalid, output wready,
    output bresp, buser, bvalid, input bready
  );
  modport rd_slv (
    input araddr, arprot, aruser, arvalid, output arready,
    output rdata, rresp, ruser, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one AXI-Lite
// transaction out, one completion back, with a watchdog on the response phase.
module axil_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  taxi_axil_if.wr_mst         m_axil_wr,
  taxi_axil_if.rd_mst         m_axil_rd
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RD,
    S_RDD,
    S_RSP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [CNT_W-1:0]    r_wdog_cnt;
  logic                r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_timeout;

  logic w_awvalid;
  logic w_wvalid;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_in_rsp_wait;
  logic w_wdog_expire;
  logic w_enter_wait;

  assign w_awvalid     = (r_state == S_WR) && !r_aw_done;
  assign w_wvalid      = (r_state == S_WR) && !r_w_done;
  assign w_aw_hs       = w_awvalid && m_axil_wr.awready;
  assign w_w_hs        = w_wvalid && m_axil_wr.wready;
  assign w_in_rsp_wait = (r_state == S_WB) || (r_state == S_RDD);
  // Expiry on the cycle the count would reach TIMEOUT_CYC; a same-cycle bvalid/rvalid still wins.
  assign w_wdog_expire = (TIMEOUT_CYC != 0) && w_in_rsp_wait && (r_wdog_cnt == WDOG_LAST);
  assign w_enter_wait  = ((w_next == S_WB) || (w_next == S_RDD)) && (w_next != r_state);

  // NOTE: state register uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = cmd_write ? S_WR : S_RD;
      S_WR:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WB;
      S_WB:   if (m_axil_wr.bvalid || w_wdog_expire) w_next = S_RSP;
      S_RD:   if (m_axil_rd.arready) w_next = S_RDD;
      S_RDD:  if (m_axil_rd.rvalid || w_wdog_expire) w_next = S_RSP;
      S_RSP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_wdog_cnt    <= '0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;

      if (w_enter_wait)                         r_wdog_cnt <= '0;
      else if (w_in_rsp_wait && TIMEOUT_CYC != 0) r_wdog_cnt <= r_wdog_cnt + 1'b1;

      if (r_state == S_WB && w_next == S_RSP) begin
        r_rsp_write   <= 1'b1;
        r_rsp_rdata   <= '0;
        r_rsp_resp    <= m_axil_wr.bvalid ? m_axil_wr.bresp : RESP_SLVERR;
        r_rsp_timeout <= !m_axil_wr.bvalid;
      end
      if (r_state == S_RDD && w_next == S_RSP) begin
        r_rsp_write   <= 1'b0;
        r_rsp_rdata   <= m_axil_rd.rvalid ? m_axil_rd.rdata : '0;
        r_rsp_resp    <= m_axil_rd.rvalid ? m_axil_rd.rresp : RESP_SLVERR;
        r_rsp_timeout <= !m_axil_rd.rvalid;
      end
      if (r_state == S_RSP && rsp_ready) r_rsp_timeout <= 1'b0;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_RSP);
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;

  assign m_axil_wr.awaddr  = r_addr;
  assign m_axil_wr.awprot  = '0;
  assign m_axil_wr.awuser  = '0;
  assign m_axil_wr.awvalid = w_awvalid;
  assign m_axil_wr.wdata   = r_wdata;
  assign m_axil_wr.wstrb   = r_wstrb;
  assign m_axil_wr.wuser   = '0;
  assign m_axil_wr.wvalid  = w_wvalid;
  assign m_axil_wr.bready  = (r_state == S_WB);

  assign m_axil_rd.araddr  = r_addr;
  assign m_axil_rd.arprot  = '0;
  assign m_axil_rd.aruser  = '0;
  assign m_axil_rd.arvalid = (r_state == S_RD);
  assign m_axil_rd.rready  = (r_state == S_RDD);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master against a small register-file slave model
// with programmable ready/valid delays and response codes.
module tb_axil_cmd_master;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        busy;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_axil_wr(axil), .m_axil_rd(axil)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t sb_q[$];
  int   t_acc;
  logic [31:0] last_addr;
  logic [35:0] last_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model knobs and state
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic        r_never = 1'b0;
  logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
  logic [31:0] mem [8];
  int          b_hs_cnt = 0;

  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] s_awaddr, s_wdata, s_araddr, aw_hold, ar_hold;
    logic [3:0]  s_wstrb;
    logic [35:0] w_hold;
    logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic aw_trk = 0, w_trk = 0, ar_trk = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0, ar_cnt = 0;
    mem[0] = 32'h0; mem[1] = 32'hAAAA_AAAA; mem[2] = 32'h1111_1111; mem[3] = 32'h0;
    mem[4] = 32'h4444_4444; mem[5] = 32'h0; mem[6] = 32'h0; mem[7] = 32'hC0FF_EE07;
    axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = 0; axil.buser = 0;
    axil.arready = 0; axil.rvalid = 0; axil.rdata = 0; axil.rresp = 0; axil.ruser = 0;
    forever begin
      @(negedge clk);
      aw_hs = axil.awvalid && axil.awready;
      w_hs  = axil.wvalid && axil.wready;
      b_hs  = axil.bvalid && axil.bready;
      ar_hs = axil.arvalid && axil.arready;
      r_hs  = axil.rvalid && axil.rready;
      s_awaddr = axil.awaddr; s_wdata = axil.wdata; s_wstrb = axil.wstrb; s_araddr = axil.araddr;
      if (axil.awvalid) begin
        if (aw_trk) check("awaddr_stable", s_awaddr, aw_hold);
        else begin aw_trk = 1; aw_hold = s_awaddr; end
      end
      if (axil.wvalid) begin
        if (w_trk) check("wpayload_stable", {s_wstrb, s_wdata}, w_hold);
        else begin w_trk = 1; w_hold = {s_wstrb, s_wdata}; end
      end
      if (axil.arvalid) begin
        if (ar_trk) check("araddr_stable", s_araddr, ar_hold);
        else begin ar_trk = 1; ar_hold = s_araddr; end
      end
      if (aw_hs || !axil.awvalid) aw_trk = 0;
      if (w_hs || !axil.wvalid)   w_trk = 0;
      if (ar_hs || !axil.arvalid) ar_trk = 0;
      if (aw_hs) check("awaddr", s_awaddr, last_addr);
      if (w_hs)  check("wpayload", {s_wstrb, s_wdata}, last_wr);
      if (ar_hs) check("araddr", s_araddr, last_addr);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; ar_cnt = 0;
        axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.arready = 0; axil.rvalid = 0;
        continue;
      end
      if (aw_hs) begin aw_got = 1; s_awaddr = s_awaddr; end
      if (w_hs)  w_got = 1;
      if (b_hs)  begin b_pend = 0; b_hs_cnt++; end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_hold[32+b]) mem[aw_hold[4:2]][8*b +: 8] = w_hold[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end
      if (r_hs) r_pend = 0;
      if (ar_hs && !r_never) begin r_pend = 1; r_cnt = 0; axil.rdata = mem[ar_hold[4:2]]; end
      axil.awready = axil.awvalid && (aw_cnt >= aw_dly);
      aw_cnt = axil.awvalid ? aw_cnt + 1 : 0;
      axil.wready = axil.wvalid && (w_cnt >= w_dly);
      w_cnt = axil.wvalid ? w_cnt + 1 : 0;
      axil.arready = axil.arvalid && (ar_cnt >= ar_dly);
      ar_cnt = axil.arvalid ? ar_cnt + 1 : 0;
      axil.bvalid = b_pend && (b_cnt >= b_dly);
      axil.bresp  = slv_bresp;
      if (b_pend) b_cnt++;
      axil.rvalid = r_pend && (r_cnt >= r_dly);
      axil.rresp  = slv_rresp;
      if (r_pend) r_cnt++;
    end
  end

  // Monitor: every completion handshake is compared against the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("rsp_write", rsp_write, e.wr);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic push, input rsp_t exp);
    bit ok = 0;
    if (push) sb_q.push_back(exp);
    last_addr = addr; last_wr = {strb, wdata};
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; t_acc = cyc; break; end
    end
    check("cmd_accept", ok, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int exp_lat);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    check("rsp_seen", seen, 1);
    check("rsp_latency", cyc - t_acc, exp_lat);
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
  endtask

  task automatic watch_wr(input int n, input logic [7:0] exp_aw, input logic [7:0] exp_w);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("awvalid_c%0d", i + 1), axil.awvalid, exp_aw[i]);
      check($sformatf("wvalid_c%0d", i + 1), axil.wvalid, exp_w[i]);
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input rsp_t exp, input int lat);
    issue(wr, addr, wdata, strb, 1'b1, exp);
    wait_rsp(lat);
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, stable, cnt;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_payload", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, 0);
    check("rst_axi_ctl", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}, 0);
    check("const_tieoff", {axil.awprot, axil.arprot, axil.awuser, axil.wuser, axil.aruser}, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Zero-wait write then read-back
    issue(1, 32'h00, 32'h0000_0005, 4'hF, 1, '{1'b1, 32'h0, 2'b00, 1'b0});
    @(negedge clk);
    check("wr_valids_c1", {axil.awvalid, axil.wvalid}, 2'b11);
    wait_rsp(3); finish_rsp();
    txn(0, 32'h00, 32'h0, 4'h0, '{1'b0, 32'h0000_0005, 2'b00, 1'b0}, 3);

    // W before AW, AW before W, both together
    aw_dly = 2; w_dly = 0; b0 = b_hs_cnt;
    issue(1, 32'h04, 32'h1234_5678, 4'h3, 1, '{1'b1, 32'h0, 2'b00, 1'b0});
    watch_wr(4, 8'b0111, 8'b0001);
    wait_rsp(5); finish_rsp();
    check("b_hs_once_a", b_hs_cnt - b0, 1);
    aw_dly = 0; w_dly = 2; b0 = b_hs_cnt;
    issue(1, 32'h08, 32'h9ABC_DEF0, 4'hC, 1, '{1'b1, 32'h0, 2'b00, 1'b0});
    watch_wr(4, 8'b0001, 8'b0111);
    wait_rsp(5); finish_rsp();
    check("b_hs_once_b", b_hs_cnt - b0, 1);
    aw_dly = 1; w_dly = 1; b0 = b_hs_cnt; slv_bresp = 2'b10;
    issue(1, 32'h0C, 32'hDEAD_0001, 4'hF, 1, '{1'b1, 32'h0, 2'b10, 1'b0});
    watch_wr(3, 8'b011, 8'b011);
    wait_rsp(4); finish_rsp();
    check("b_hs_once_c", b_hs_cnt - b0, 1);
    aw_dly = 0; w_dly = 0; slv_bresp = 2'b00;

    // Completion back-pressure
    rsp_ready = 0;
    issue(0, 32'h1C, 32'h0, 4'h0, 1, '{1'b0, 32'hC0FF_EE07, 2'b00, 1'b0});
    wait_rsp(3);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid && rsp_rdata == 32'hC0FF_EE07 && !cmd_ready) stable++;
    end
    check("stall_stable_cycles", stable, 10);
    @(posedge clk); #1; rsp_ready = 1;
    @(negedge clk);
    check("stall_cmd_ready_hs", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_cmd_ready_after", cmd_ready, 1);
    check("stall_rsp_valid_after", rsp_valid, 0);
    @(posedge clk); #1;

    // Read watchdog expiry, then a normal write
    r_never = 1;
    issue(0, 32'h10, 32'h0, 4'h0, 1, '{1'b0, 32'h0, 2'b10, 1'b1});
    wait_rsp(10);
    check("to_rready_low", axil.rready, 0);
    check("to_flag", rsp_timeout, 1);
    finish_rsp();
    r_never = 0;
    txn(1, 32'h14, 32'h0BAD_BEEF, 4'hF, '{1'b1, 32'h0, 2'b00, 1'b0}, 3);

    // rvalid on the expiry cycle wins
    r_dly = 7;
    txn(0, 32'h14, 32'h0, 4'h0, '{1'b0, 32'h0BAD_BEEF, 2'b00, 1'b0}, 10);
    r_dly = 0;

    // Slave error code forwarded unchanged; strobed write visible
    slv_rresp = 2'b11;
    txn(0, 32'h04, 32'h0, 4'h0, '{1'b0, 32'hAAAA_5678, 2'b11, 1'b0}, 3);
    slv_rresp = 2'b00;

    // Reset in the middle of a write
    aw_dly = 5; w_dly = 5;
    issue(1, 32'h18, 32'h7777_7777, 4'hF, 0, '{1'b0, 32'h0, 2'b00, 1'b0});
    #2;
    check("pre_rst_awvalid", axil.awvalid, 1);
    rst_n = 0;
    #1;
    check("rst_mid_valids", {axil.awvalid, axil.wvalid}, 2'b00);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    @(posedge clk); @(posedge clk); #3; rst_n = 1;
    aw_dly = 0; w_dly = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("rst_no_rsp", cnt, 0);
    check("rst_cmd_ready_after", cmd_ready, 1);
    @(posedge clk); #1;
    txn(0, 32'h08, 32'h0, 4'h0, '{1'b0, 32'h9ABC_1111, 2'b00, 1'b0}, 3);

    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite initiator that turns single-beat register commands into AXI-Lite write or read transactions.
- Commands arrive on a valid/ready command port; completions return on a valid/ready response port.
- Sits between the host-side command source (debug UART bridge / test sequencer) and the axilregs register slave of the AES_UART core.
- Exactly one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, AXI-Lite address width; must match the taxi_axil_if instance.
DATA_W, 32, AXI-Lite data width; STRB_W = DATA_W/8.
TIMEOUT_CYC, 1024, response-phase watchdog length in cycles; 0 disables the watchdog.

Ports:
clk  in  1  clock, all logic rising-edge.
rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when high with cmd_valid.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data; ignored for reads.
cmd_wstrb  in  STRB_W  write strobes; ignored for reads.
rsp_valid  out  1  completion present.
rsp_ready  in  1  completion consumed.
rsp_write  out  1  echo of cmd_write.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_resp  out  2  bresp/rresp, or 2'b10 on timeout.
rsp_timeout  out  1  watchdog fired.
busy  out  1  high in every state except IDLE.
m_axil_wr  taxi_axil_if.wr_mst  if  AXI-Lite write channels (aw, w, b).
m_axil_rd  taxi_axil_if.rd_mst  if  AXI-Lite read channels (ar, r).

Behaviour:
- Reset (rst_n low, asynchronous, immediate): state = IDLE; cmd_ready = 1; all of the following are 0: rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy, awvalid, wvalid, bready, arvalid, rready, watchdog counter.
- Reset mid-transaction: all AXI valids and readies drop immediately and the in-flight command is discarded.
- Constant outputs: awprot, arprot, awuser, wuser and aruser are tied to 0.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch addr/wdata/wstrb/write. Go to WR (cmd_write = 1) or RD (cmd_write = 0).
  - WR: awvalid and wvalid rise on the cycle after acceptance, together.
    - Each valid is tracked by its own done flag and drops on the cycle after its own ready is sampled high. awready and wready may arrive in either order or in the same cycle.
    - Once both handshakes are done, go to WB. A bvalid arriving earlier is held by the slave.
  - WB: bready = 1. On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0 and rsp_write = 1, go to RSP.
  - RD: arvalid = 1 until arready is sampled high, then go to RDD.
  - RDD: rready = 1. On rvalid, capture rdata and rresp, set rsp_write = 0, go to RSP.
  - RSP: rsp_valid = 1 with stable payload. On rsp_ready, go to IDLE; cmd_ready returns 1 on the following cycle.
- Latency against a zero-wait slave:
  - Write: acceptance, AW/W, B, RSP = rsp_valid 3 cycles after command acceptance.
  - Read: acceptance, AR, R, RSP = rsp_valid 3 cycles after command acceptance.
- AXI payload (awaddr/wdata/wstrb/araddr) is registered and stays stable while the matching valid is high. The address is passed through unmodified, with no alignment.
- Watchdog (TIMEOUT_CYC > 0):
  - The counter clears on entry to WB or RDD and increments every cycle while in those states.
  - When it reaches TIMEOUT_CYC: drop bready/rready, go to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - A bvalid/rvalid arriving in the same cycle as expiry wins: normal completion, rsp_timeout = 0.
  - Address/data phases (WR, RD) have no watchdog, because valid must not be withdrawn.
- rsp_timeout clears on the RSP-to-IDLE transition.
- Slave responses 2'b10 and 2'b11 are forwarded unchanged.

Test Plan:
- Write cmd addr 0x00, wdata 0x0000_0005, wstrb 0xF to the axilregs slave -> awvalid/wvalid high the cycle after acceptance; rsp_valid 3 cycles after acceptance, rsp_write = 1, rsp_resp = 0; then a read of 0x00 returns rsp_rdata = 0x0000_0005.
- Slave model gives wready 2 cycles before awready, then the reverse, then both together -> wvalid/awvalid each drop independently; exactly one B handshake; payload stable throughout.
- Read 0x1C with rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stable all 10 cycles; cmd_ready = 0 until the cycle after rsp_ready.
- TIMEOUT_CYC = 8, slave never asserts rvalid -> rsp_valid 8 cycles after RDD entry, rsp_timeout = 1, rsp_resp = 2'b10, rready low; a follow-up write completes normally.
- rvalid on the exact expiry cycle -> normal completion, rsp_timeout = 0, rdata captured.
- rst_n low while awvalid is high -> awvalid, wvalid and busy are 0 in the same cycle; after release, cmd_ready = 1 and no response is emitted for the lost command.
